// File: rtl/oem_sort_drain.sv
`default_nettype none
// ============================================================================
// Module   : oem_sort_drain
// Brief    : Captures NB sorter output batches into a frame buffer, then
//            streams the N-element frame one element per cycle (valid/ready).
//            Optional order checker: define OEM_SORT_DRAIN_CHECK_EN.
// Revision : 1.0 - initial release
// ============================================================================
module oem_sort_drain #(
    parameter int DW = 6,
    parameter int P  = 8,
    parameter int N  = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            vin,
    input  logic            en_in,
    input  logic            rev,
    input  logic [P*DW-1:0] din,
    output logic [DW-1:0]   dout,
    output logic            dout_valid,
    input  logic            dout_ready,
    output logic            dout_last,
    output logic            busy,
    output logic            ovf,
    output logic            sort_err
);

    localparam int NB = N / P;
    localparam int BW = $clog2(NB + 1);
    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam logic [BW-1:0] c_LAST_B = BW'(NB - 1);
    localparam logic [IW-1:0] c_LAST_I = IW'(N - 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_CAPTURE = 2'd1,
        S_DRAIN   = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_state_nx;

    logic [N*DW-1:0] r_frame;
    logic [N*DW-1:0] w_frame_nx;
    logic [BW-1:0]   r_bcnt;
    logic [BW-1:0]   w_wr_b;
    logic [IW-1:0]   r_idx;
    logic [IW-1:0]   w_idx_inc;
    logic            r_rev;
    logic            w_rev_eff;
    logic [DW-1:0]   r_dout;
    logic            r_valid;
    logic            r_last;
    logic            r_busy;
    logic            r_ovf;

    logic            w_acc;
    logic            w_store;
    logic            w_final;
    logic            w_hs;
    logic            w_done;
    logic [IW-1:0]   w_pick_idx;
    logic            w_pick_rev;
    logic [IW-1:0]   w_pos;
    logic [DW-1:0]   w_pick;

    assign w_acc     = vin & en_in;
    assign w_store   = w_acc & (r_state != S_DRAIN);
    assign w_wr_b    = (r_state == S_IDLE) ? '0 : r_bcnt;
    assign w_final   = w_store & (w_wr_b == c_LAST_B);
    assign w_hs      = (r_state == S_DRAIN) & r_valid & dout_ready;
    assign w_done    = w_hs & (r_idx == c_LAST_I);
    assign w_idx_inc = r_idx + 1'b1;
    assign w_rev_eff = (r_state == S_IDLE) ? rev : r_rev;

    // Frame image as it will look after this edge, so the first element
    // can be registered in the same edge that stores the final batch.
    always_comb begin
        w_frame_nx = r_frame;
        for (int b = 0; b < NB; b++) begin
            if (w_store && (w_wr_b == BW'(b))) begin
                w_frame_nx[b*P*DW +: P*DW] = din;
            end
        end
    end

    assign w_pick_idx = w_final ? '0 : w_idx_inc;
    assign w_pick_rev = w_final ? w_rev_eff : r_rev;

    always_comb begin
        w_pos  = w_pick_rev ? (c_LAST_I - w_pick_idx) : w_pick_idx;
        w_pick = '0;
        for (int e = 0; e < N; e++) begin
            if (w_pos == IW'(e)) begin
                w_pick = w_frame_nx[e*DW +: DW];
            end
        end
    end

    always_comb begin
        w_state_nx = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_final)    w_state_nx = S_DRAIN;
                else if (w_acc) w_state_nx = S_CAPTURE;
            end
            S_CAPTURE: begin
                if (w_final)    w_state_nx = S_DRAIN;
            end
            S_DRAIN: begin
                if (w_done)     w_state_nx = S_IDLE;
            end
            default:            w_state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            r_busy  <= (w_state_nx != S_IDLE);
        end
    end

    // Buffer contents need no reset; they are always rewritten before use.
    always_ff @(posedge clk) begin
        r_frame <= w_frame_nx;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_bcnt  <= '0;
            r_idx   <= '0;
            r_rev   <= 1'b0;
            r_dout  <= '0;
            r_valid <= 1'b0;
            r_last  <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            if (w_store) begin
                r_bcnt <= w_wr_b + 1'b1;
            end else if (w_done) begin
                r_bcnt <= '0;
            end

            if ((r_state == S_IDLE) && w_acc) begin
                r_rev <= rev;
            end

            if (w_acc && (r_state == S_DRAIN)) begin
                r_ovf <= 1'b1;
            end

            if (w_final) begin
                r_dout  <= w_pick;
                r_valid <= 1'b1;
                r_last  <= (c_LAST_I == '0);
                r_idx   <= '0;
            end else if (w_done) begin
                r_valid <= 1'b0;
                r_last  <= 1'b0;
                r_idx   <= '0;
            end else if (w_hs) begin
                r_dout  <= w_pick;
                r_idx   <= w_idx_inc;
                r_last  <= (w_idx_inc == c_LAST_I);
            end
        end
    end

    assign dout       = r_dout;
    assign dout_valid = r_valid;
    assign dout_last  = r_last;
    assign busy       = r_busy;
    assign ovf        = r_ovf;

`ifdef OEM_SORT_DRAIN_CHECK_EN
    logic [DW-1:0] r_prev;
    logic          r_err;
    logic          w_bad;

    // Index 0 has no predecessor in the frame, so it is never flagged.
    assign w_bad = r_rev ? (r_dout > r_prev) : (r_dout < r_prev);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_prev <= '0;
            r_err  <= 1'b0;
        end else if (w_hs) begin
            r_prev <= r_dout;
            if ((r_idx != '0) && w_bad) begin
                r_err <= 1'b1;
            end
        end
    end

    assign sort_err = r_err;
`else
    assign sort_err = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_oem_sort_drain.sv
`default_nettype none
// Self-checking bench for oem_sort_drain: directed frames from the test plan
// plus randomized frames, checked against a frame-level reference model.
module tb_oem_sort_drain;

    localparam int DW = 6;
    localparam int P  = 8;
    localparam int N  = 16;
    localparam int NB = N / P;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            vin = 1'b0;
    logic            en_in = 1'b0;
    logic            rev = 1'b0;
    logic            dout_ready = 1'b0;
    logic [P*DW-1:0] din = '0;
    logic [DW-1:0]   dout;
    logic            dout_valid;
    logic            dout_last;
    logic            busy;
    logic            ovf;
    logic            sort_err;

    int n_chk  = 0;
    int n_pass = 0;
    int bat [NB][P];
    int exp_a [N];
    bit exp_ovf = 1'b0;
    bit exp_err = 1'b0;
    int rpat [6] = '{1, 0, 0, 1, 0, 1};

    always #5 clk = ~clk;

    oem_sort_drain #(.DW(DW), .P(P), .N(N)) u_dut (
        .clk        (clk),
        .rst        (rst),
        .vin        (vin),
        .en_in      (en_in),
        .rev        (rev),
        .din        (din),
        .dout       (dout),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
        .dout_last  (dout_last),
        .busy       (busy),
        .ovf        (ovf),
        .sort_err   (sort_err)
    );

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pack(input int b);
        for (int k = 0; k < P; k++) din[k*DW +: DW] = DW'(bat[b][k]);
    endtask

    task automatic do_reset();
        vin = 1'b0; en_in = 1'b0; dout_ready = 1'b0;
        rst = 1'b1;
        #1;
        exp_ovf = 1'b0;
        exp_err = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        tick();
    endtask

    // rmode: 0 = always ready, 1 = fixed stall pattern, 2 = random.
    // ovf_at: inject a batch in DRAIN while cnt == ovf_at (-1 = never).
    // ovf_last: inject a batch coincident with the final handshake.
    // abort_at: assert reset once cnt handshakes are done (-1 = never).
    task automatic run_frame(input bit rv0, input bit rv1, input int rmode,
                             input int ovf_at, input bit ovf_last, input int abort_at);
        int  cnt;
        int  cyc;
        bit  stall;
        int  hd;
        int  hl;
        bit  rdy;
        for (int i = 0; i < N; i++) begin
            int pos;
            pos = rv0 ? (N - 1 - i) : i;
            exp_a[i] = bat[pos / P][pos % P];
        end
        vin = 1'b1; en_in = 1'b1; rev = rv0; pack(0);
        tick();
        chk("valid_after_b0", dout_valid, 0);
        chk("busy_capture", busy, 1);
        rev = rv1; pack(1);
        tick();
        vin = 1'b0; en_in = 1'b0; rev = 1'b0;
        chk("valid_rise", dout_valid, 1);
        cnt = 0; cyc = 0; stall = 1'b0; hd = 0; hl = 0;
        while (cnt < N && cyc < 400) begin
            chk("ovf", ovf, exp_ovf);
            chk("sort_err", sort_err, exp_err);
            chk("valid", dout_valid, 1);
            chk("busy", busy, 1);
            if (stall) begin
                chk("hold_dout", dout, hd);
                chk("hold_last", dout_last, hl);
            end
            if (cnt == abort_at) begin
                dout_ready = 1'b0;
                rst = 1'b1;
                #1;
                chk("abort_valid", dout_valid, 0);
                chk("abort_busy", busy, 0);
                chk("abort_last", dout_last, 0);
                chk("abort_ovf", ovf, 0);
                exp_ovf = 1'b0;
                exp_err = 1'b0;
                @(negedge clk);
                rst = 1'b0;
                tick();
                tick();
                chk("abort_idle_valid", dout_valid, 0);
                chk("abort_idle_busy", busy, 0);
                return;
            end
            case (rmode)
                0:       rdy = 1'b1;
                1:       rdy = rpat[cyc % 6] != 0;
                default: rdy = $urandom_range(0, 1) != 0;
            endcase
            dout_ready = rdy;
            if ((cnt == ovf_at) || (ovf_last && cnt == N - 1 && rdy)) begin
                vin = 1'b1; en_in = 1'b1; din = '1;
                exp_ovf = 1'b1;
            end else begin
                vin = 1'b0; en_in = 1'b0;
            end
            if (rdy) begin
                chk("data", dout, exp_a[cnt]);
                chk("last", dout_last, (cnt == N - 1) ? 1 : 0);
`ifdef OEM_SORT_DRAIN_CHECK_EN
                if (cnt > 0 && (rv0 ? (exp_a[cnt] > exp_a[cnt-1])
                                    : (exp_a[cnt] < exp_a[cnt-1])))
                    exp_err = 1'b1;
`endif
                cnt++;
            end
            stall = !rdy;
            hd = dout;
            hl = dout_last;
            tick();
            cyc++;
        end
        vin = 1'b0; en_in = 1'b0; dout_ready = 1'b0;
        if (cyc >= 400) chk("drain_timeout", cnt, N);
        chk("valid_end", dout_valid, 0);
        chk("last_end", dout_last, 0);
        chk("busy_end", busy, 0);
        chk("ovf_end", ovf, exp_ovf);
        chk("err_end", sort_err, exp_err);
    endtask

    task automatic load_sorted();
        bat[0] = '{5, 7, 12, 15, 19, 21, 26, 29};
        bat[1] = '{37, 38, 41, 42, 50, 51, 54, 56};
    endtask

    initial begin
        tick();
        tick();
        chk("rst_valid", dout_valid, 0);
        chk("rst_last", dout_last, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ovf", ovf, 0);
        chk("rst_err", sort_err, 0);
        chk("rst_dout", dout, 0);
        @(negedge clk);
        rst = 1'b0;
        tick();

        load_sorted();
        run_frame(1'b0, 1'b0, 0, -1, 1'b0, -1);
        run_frame(1'b1, 1'b0, 0, -1, 1'b0, -1);
        run_frame(1'b0, 1'b0, 1, -1, 1'b0, -1);

        vin = 1'b1; en_in = 1'b0; din = '1;
        tick();
        vin = 1'b0;
        chk("gate_busy", busy, 0);
        chk("gate_valid", dout_valid, 0);
        tick();
        chk("gate_busy2", busy, 0);
        run_frame(1'b0, 1'b1, 0, -1, 1'b0, -1);

        run_frame(1'b0, 1'b0, 0, -1, 1'b1, -1);
        tick();
        chk("ovf_sticky", ovf, 1);

        run_frame(1'b0, 1'b0, 0, -1, 1'b0, 5);
        for (int k = 0; k < P; k++) begin
            bat[0][k] = 0;
            bat[1][k] = 63;
        end
        run_frame(1'b0, 1'b0, 0, -1, 1'b0, -1);

        load_sorted();
        run_frame(1'b1, 1'b1, 1, 4, 1'b0, -1);

        for (int f = 0; f < 6; f++) begin
            for (int b = 0; b < NB; b++)
                for (int k = 0; k < P; k++)
                    bat[b][k] = $urandom_range(0, 63);
            run_frame($urandom_range(0, 1) != 0, $urandom_range(0, 1) != 0, 2, -1, 1'b0, -1);
        end

        do_reset();
        bat[0] = '{5, 15, 19, 26, 37, 41, 50, 54};
        bat[1] = '{7, 12, 21, 29, 38, 42, 51, 56};
        run_frame(1'b0, 1'b0, 0, -1, 1'b0, -1);
        tick();
        chk("err_final", sort_err, exp_err);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
